stream_mux2_rr: RTL and testbench
=================================

// Module: stream_mux2_rr
// PURPOSE
//  - 2:1 stream multiplexer with valid/ready handshake on every port.
//  - Merges two source streams onto one sink, arbitrating round-robin when both are valid.
//  - Output is a registered stage, so the sink sees the beat one cycle later.
//  - Reports the winning source on out_sel.
//  - Inverse of the 1:2 select-steered demux: it puts demuxed lanes back onto a single channel.
// PARAMETERS
//  - W  8  data width of in0_data, in1_data and out_data, in bits (W >= 1).
// PORTS
//  clk        in   1  single clock; rising edge.
//  rst_n      in   1  asynchronous, active-low reset.
//  in0_valid  in   1  source 0 has a beat.
//  in0_data   in   W  source 0 data.
//  in0_last   in   1  source 0 end-of-packet; used only with STREAM_MUX_LOCK_EN.
//  in0_ready  out  1  source 0 beat accepted this cycle.
//  in1_valid  in   1  source 1 has a beat.
//  in1_data   in   W  source 1 data.
//  in1_last   in   1  source 1 end-of-packet; used only with STREAM_MUX_LOCK_EN.
//  in1_ready  out  1  source 1 beat accepted this cycle.
//  out_valid  out  1  output register holds a beat.
//  out_data   out  W  registered data.
//  out_last   out  1  registered last flag; 0 without the macro.
//  out_sel    out  1  source of the current output beat (0 or 1).
//  out_ready  in   1  sink accepts the beat.
// BEHAVIOUR
//  - Reset (async assert, sync release):
//    - out_valid=0, out_data=0, out_last=0, out_sel=0.
//    - last_gnt=1, so source 0 wins the first contention.
//    - FSM returns to IDLE.
//  - Handshakes:
//    - A transfer happens when valid and ready are both high at a rising edge.
//    - Holding valid/data stable until accepted is the source's obligation; the block does not check it.
//  - Register advance and grant:
//    - adv = ~out_valid | out_ready. The register is loaded whenever adv=1.
//    - gnt is computed combinationally:
//      - only one source valid -> that source;
//      - both valid -> ~last_gnt (round-robin).
//    - in_k_ready = adv & (gnt==k). The ready of the losing source is 0.
//    - No combinational path from in*_valid to in*_ready other than through gnt; out_ready reaches in*_ready via adv.
//  - Accept (winner has valid & ready):
//    - load out_data/out_last/out_sel from the winner;
//    - set out_valid=1;
//    - last_gnt <= gnt.
//  - No source valid and adv=1: out_valid <= 0.
//  - Timing:
//    - latency is 1 cycle from input accept to out_valid;
//    - throughput is 1 beat/cycle while out_ready=1;
//    - with both sources valid continuously, they alternate 0,1,0,1...
//  - Backpressure: while out_ready=0 and out_valid=1, out_* hold stable and both readies are 0.
//  - Reset mid-transfer: an in-flight output beat is dropped; there is no replay.
// CONFIGURATION
//  - Macro STREAM_MUX_LOCK_EN defined: packet lock.
//    - FSM states IDLE, LOCK0, LOCK1.
//    - IDLE: an accepted beat with last=0 from source k moves the FSM to LOCKk.
//    - LOCKk: gnt is forced to k (the other source waits even if k is idle); stay until an accepted beat from k has last=1, then go to IDLE.
//    - last=1 on a first beat in IDLE stays in IDLE (single-beat packet).
//    - Round-robin (last_gnt) updates only at packet boundaries.
//  - Macro undefined:
//    - per-beat arbitration; there is no FSM;
//    - in*_last are ignored and out_last is tied to 0.
// STRUCTURE
//  - Package stream_mux_pkg holds:
//    - typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} mux_state_t;
//    - localparam SEL_IN0=1'b0, SEL_IN1=1'b1.
//  - One sub-module, stream_pipe_reg:
//    - W+2-bit output register with valid/ready;
//    - exports adv;
//    - reused by later stream blocks.
//  - Top level contains arbiter, grant mux and lock FSM.
// TESTING
//  - Reset: rst_n=0 mid-stream -> out_valid=0 immediately (async); after release, first contention is won by in0.
//  - Single source: in0 sends 0x11,0x22,0x33, out_ready=1 -> out_data 0x11,0x22,0x33 on consecutive cycles one cycle later, out_sel=0.
//  - Contention: both valid constantly, in0=0xA*, in1=0xB* -> out_sel sequence 0,1,0,1; no beat lost or duplicated.
//  - Backpressure: out_ready=0 for 3 cycles with out_valid=1 -> out_data stable, in0_ready=in1_ready=0; resumes with no drop.
//  - Lock (macro on): in0 sends a 3-beat packet (last on beat 3) while in1 is always valid -> in1 waits; three consecutive out_sel=0, then 1.
//  - Lock off: same stimulus -> out_sel alternates 0,1,0,1 and out_last=0.

Source files
------------

// File: rtl/stream_mux_pkg.sv
// Shared types and constants for the stream multiplexer family.
// The lock state type is only referenced when STREAM_MUX_LOCK_EN is defined.
package stream_mux_pkg;

   typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} mux_state_t;

   localparam logic SEL_IN0 = 1'b0;
   localparam logic SEL_IN1 = 1'b1;

endpackage

// File: rtl/stream_pipe_reg.sv
// Single valid/ready register stage carrying a PW-bit payload.
// Exposes adv so the upstream arbiter can steer its readies from it.
module stream_pipe_reg #(
   parameter int unsigned PW = 10
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   input  logic [PW-1:0] in_payload,
   output logic          adv,
   output logic          out_valid,
   output logic [PW-1:0] out_payload,
   input  logic          out_ready
);

   logic          valid_d;
   logic          valid_q;
   logic [PW-1:0] payload_d;
   logic [PW-1:0] payload_q;

   // The stage may take a new beat when empty or when its beat leaves this cycle.
   always_comb begin
      adv = ~valid_q | out_ready;
   end

   // Next-state of the stage; payload holds when nothing new is loaded.
   always_comb begin
      valid_d   = valid_q;
      payload_d = payload_q;
      if (adv) begin
         valid_d = in_valid;
         if (in_valid) begin
            payload_d = in_payload;
         end else begin
            payload_d = payload_q;
         end
      end else begin
         valid_d   = valid_q;
         payload_d = payload_q;
      end
   end

   // Stage register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q   <= 1'b0;
         payload_q <= {PW{1'b0}};
      end else begin
         valid_q   <= valid_d;
         payload_q <= payload_d;
      end
   end

   assign out_valid   = valid_q;
   assign out_payload = payload_q;

endmodule

// File: rtl/stream_mux2_rr.sv
// 2:1 round-robin stream mux with a registered output stage.
// Define STREAM_MUX_LOCK_EN to hold the grant for a whole packet (in*_last).
module stream_mux2_rr
   import stream_mux_pkg::*;
#(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in0_valid,
   input  logic [W-1:0] in0_data,
   input  logic         in0_last,
   output logic         in0_ready,
   input  logic         in1_valid,
   input  logic [W-1:0] in1_data,
   input  logic         in1_last,
   output logic         in1_ready,
   output logic         out_valid,
   output logic [W-1:0] out_data,
   output logic         out_last,
   output logic         out_sel,
   input  logic         out_ready
);

   logic         rr_gnt_s;
   logic         gnt_s;
   logic         win_valid_s;
   logic [W-1:0] win_data_s;
   logic         win_last_s;
   logic         adv_s;
   logic         accept_s;
   logic         last_gnt_d;
   logic         last_gnt_q;
   logic [W+1:0] out_payload_s;

   // Round-robin choice; with nobody valid the value is irrelevant.
   always_comb begin
      if (in0_valid && !in1_valid) begin
         rr_gnt_s = SEL_IN0;
      end else if (in1_valid && !in0_valid) begin
         rr_gnt_s = SEL_IN1;
      end else begin
         rr_gnt_s = ~last_gnt_q;
      end
   end

`ifdef STREAM_MUX_LOCK_EN
   mux_state_t state_d;
   mux_state_t state_q;

   // Lock state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Enter a lock on a non-final first beat, leave it on the owner's last beat.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (accept_s && !win_last_s) begin
               state_d = (gnt_s == SEL_IN1) ? LOCK1 : LOCK0;
            end else begin
               state_d = IDLE;
            end
         end
         LOCK0, LOCK1: begin
            if (accept_s && win_last_s) begin
               state_d = IDLE;
            end else begin
               state_d = state_q;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // While locked the owner keeps the grant even when it has no beat.
   always_comb begin
      case (state_q)
         LOCK0:   gnt_s = SEL_IN0;
         LOCK1:   gnt_s = SEL_IN1;
         default: gnt_s = rr_gnt_s;
      endcase
   end

   // Last flag of the winning source.
   always_comb begin
      win_last_s = (gnt_s == SEL_IN1) ? in1_last : in0_last;
   end
`else
   logic unused_last_s;

   // Per-beat arbitration only.
   always_comb begin
      gnt_s      = rr_gnt_s;
      win_last_s = 1'b0;
   end

   assign unused_last_s = in0_last ^ in1_last;
`endif

   // Grant mux and handshake steering.
   always_comb begin
      win_valid_s = (gnt_s == SEL_IN1) ? in1_valid : in0_valid;
      win_data_s  = (gnt_s == SEL_IN1) ? in1_data  : in0_data;
      accept_s    = adv_s & win_valid_s;
      in0_ready   = adv_s & (gnt_s == SEL_IN0);
      in1_ready   = adv_s & (gnt_s == SEL_IN1);
   end

   // Inside a lock gnt equals the owner, so updating on every accept
   // only changes last_gnt at packet boundaries.
   always_comb begin
      if (accept_s) begin
         last_gnt_d = gnt_s;
      end else begin
         last_gnt_d = last_gnt_q;
      end
   end

   // Round-robin history; reset to 1 so source 0 wins the first contention.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_gnt_q <= 1'b1;
      end else begin
         last_gnt_q <= last_gnt_d;
      end
   end

   stream_pipe_reg #(
      .PW (W + 2)
   ) u_out_reg (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (win_valid_s),
      .in_payload  ({win_last_s, gnt_s, win_data_s}),
      .adv         (adv_s),
      .out_valid   (out_valid),
      .out_payload (out_payload_s),
      .out_ready   (out_ready)
   );

   assign out_last = out_payload_s[W+1];
   assign out_sel  = out_payload_s[W];
   assign out_data = out_payload_s[W-1:0];

endmodule

// File: tb/tb_stream_mux2_rr.sv
// Directed bench for stream_mux2_rr; packet-lock expectations follow STREAM_MUX_LOCK_EN.
module tb_stream_mux2_rr;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in0_valid;
   logic [7:0] in0_data;
   logic       in0_last;
   logic       in0_ready;
   logic       in1_valid;
   logic [7:0] in1_data;
   logic       in1_last;
   logic       in1_ready;
   logic       out_valid;
   logic [7:0] out_data;
   logic       out_last;
   logic       out_sel;
   logic       out_ready;

   int checks = 0;
   int errors = 0;

   stream_mux2_rr #(.W(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in0_valid (in0_valid),
      .in0_data  (in0_data),
      .in0_last  (in0_last),
      .in0_ready (in0_ready),
      .in1_valid (in1_valid),
      .in1_data  (in1_data),
      .in1_last  (in1_last),
      .in1_ready (in1_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_last  (out_last),
      .out_sel   (out_sel),
      .out_ready (out_ready)
   );

   always #5 clk = ~clk;

   task automatic test_reset();
      rst_n = 1'b0;
      in0_valid = 1'b0; in0_data = 8'h00; in0_last = 1'b1;
      in1_valid = 1'b0; in1_data = 8'h00; in1_last = 1'b1;
      out_ready = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if ({out_valid, out_last, out_sel, out_data} !== 11'd0) begin
         errors++;
         $display("FAIL reset_state: got v=%b l=%b s=%b d=%h, want all 0", out_valid, out_last, out_sel, out_data);
      end
      rst_n = 1'b1;
      in0_valid = 1'b1; in0_data = 8'h55; out_ready = 1'b0;
      @(negedge clk);
      checks++;
      if ({out_valid, out_data} !== {1'b1, 8'h55}) begin
         errors++;
         $display("FAIL reset_preload: got v=%b d=%h, want v=1 d=55", out_valid, out_data);
      end
      in0_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_async: got out_valid=%b, want 0", out_valid);
      end
      @(negedge clk);
      rst_n = 1'b1;
      in0_valid = 1'b1; in0_data = 8'hA0;
      in1_valid = 1'b1; in1_data = 8'hB0;
      out_ready = 1'b1;
      #1;
      checks++;
      if ({in0_ready, in1_ready} !== 2'b10) begin
         errors++;
         $display("FAIL reset_first_ready: got in0_ready=%b in1_ready=%b, want 1 0", in0_ready, in1_ready);
      end
      @(negedge clk);
      checks++;
      if ({out_valid, out_sel, out_data} !== {1'b1, 1'b0, 8'hA0}) begin
         errors++;
         $display("FAIL reset_first_win: got v=%b s=%b d=%h, want v=1 s=0 d=a0", out_valid, out_sel, out_data);
      end
      in0_valid = 1'b0; in1_valid = 1'b0;
   endtask

   task automatic test_single_source();
      logic [7:0] vec [3];
      vec = '{8'h11, 8'h22, 8'h33};
      in0_valid = 1'b1; in0_data = vec[0]; out_ready = 1'b1;
      #1;
      checks++;
      if (in0_ready !== 1'b1) begin
         errors++;
         $display("FAIL single_ready: got in0_ready=%b, want 1", in0_ready);
      end
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         checks++;
         if ({out_valid, out_sel, out_data} !== {1'b1, 1'b0, vec[k]}) begin
            errors++;
            $display("FAIL single_beat%0d: got v=%b s=%b d=%h, want v=1 s=0 d=%h", k, out_valid, out_sel, out_data, vec[k]);
         end
         if (k < 2) in0_data = vec[k+1];
         else in0_valid = 1'b0;
      end
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL single_drain: got out_valid=%b, want 0", out_valid);
      end
   endtask

   task automatic test_contention();
      logic [7:0] i0;
      logic [7:0] i1;
      logic       exp_sel;
      logic [7:0] exp_d;
      in1_valid = 1'b1; in1_data = 8'h9B; out_ready = 1'b1;
      @(negedge clk);
      checks++;
      if ({out_valid, out_sel, out_data} !== {1'b1, 1'b1, 8'h9B}) begin
         errors++;
         $display("FAIL contention_prefix: got v=%b s=%b d=%h, want v=1 s=1 d=9b", out_valid, out_sel, out_data);
      end
      i0 = 8'd0; i1 = 8'd0; exp_sel = 1'b0;
      in0_valid = 1'b1; in0_data = 8'hA0;
      in1_data = 8'hB0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         exp_d = exp_sel ? (8'hB0 + i1) : (8'hA0 + i0);
         checks++;
         if ({out_valid, out_sel, out_data} !== {1'b1, exp_sel, exp_d}) begin
            errors++;
            $display("FAIL contention_beat%0d: got v=%b s=%b d=%h, want v=1 s=%b d=%h", k, out_valid, out_sel, out_data, exp_sel, exp_d);
         end
         if (exp_sel) i1 = i1 + 8'd1;
         else i0 = i0 + 8'd1;
         in0_data = 8'hA0 + i0;
         in1_data = 8'hB0 + i1;
         exp_sel = ~exp_sel;
         #1;
         checks++;
         if ({in0_ready, in1_ready} !== {~exp_sel, exp_sel}) begin
            errors++;
            $display("FAIL contention_ready%0d: got in0_ready=%b in1_ready=%b, want %b %b", k, in0_ready, in1_ready, ~exp_sel, exp_sel);
         end
      end
      in0_valid = 1'b0; in1_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL contention_drain: got out_valid=%b, want 0", out_valid);
      end
   endtask

   task automatic test_backpressure();
      in0_valid = 1'b1; in0_data = 8'h5A; out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      in0_data = 8'h5B;
      in1_valid = 1'b1; in1_data = 8'hC1;
      for (int k = 0; k < 3; k++) begin
         #1;
         checks++;
         if ({out_valid, out_sel, out_data, in0_ready, in1_ready} !== {1'b1, 1'b0, 8'h5A, 2'b00}) begin
            errors++;
            $display("FAIL backpressure_hold%0d: got v=%b s=%b d=%h r0=%b r1=%b, want v=1 s=0 d=5a r0=0 r1=0",
                     k, out_valid, out_sel, out_data, in0_ready, in1_ready);
         end
         @(negedge clk);
      end
      out_ready = 1'b1;
      #1;
      checks++;
      if ({in0_ready, in1_ready} !== 2'b01) begin
         errors++;
         $display("FAIL backpressure_release_ready: got in0_ready=%b in1_ready=%b, want 0 1", in0_ready, in1_ready);
      end
      @(negedge clk);
      checks++;
      if ({out_valid, out_sel, out_data} !== {1'b1, 1'b1, 8'hC1}) begin
         errors++;
         $display("FAIL backpressure_resume1: got v=%b s=%b d=%h, want v=1 s=1 d=c1", out_valid, out_sel, out_data);
      end
      in1_valid = 1'b0;
      @(negedge clk);
      checks++;
      if ({out_valid, out_sel, out_data} !== {1'b1, 1'b0, 8'h5B}) begin
         errors++;
         $display("FAIL backpressure_resume2: got v=%b s=%b d=%h, want v=1 s=0 d=5b", out_valid, out_sel, out_data);
      end
      in0_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL backpressure_drain: got out_valid=%b, want 0", out_valid);
      end
   endtask

   task automatic test_lock();
      logic [7:0] exp_d [5];
      logic [4:0] exp_sel;
      logic [4:0] exp_last;
      logic [7:0] i0;
      logic [7:0] i1;
`ifdef STREAM_MUX_LOCK_EN
      exp_d    = '{8'hD0, 8'hD1, 8'hD2, 8'hE0, 8'hE1};
      exp_sel  = 5'b11000;
      exp_last = 5'b11100;
`else
      exp_d    = '{8'hD0, 8'hE0, 8'hD1, 8'hE1, 8'hD2};
      exp_sel  = 5'b01010;
      exp_last = 5'b00000;
`endif
      in1_valid = 1'b1; in1_data = 8'h9E; in1_last = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      checks++;
      if ({out_valid, out_sel, out_data} !== {1'b1, 1'b1, 8'h9E}) begin
         errors++;
         $display("FAIL lock_prefix: got v=%b s=%b d=%h, want v=1 s=1 d=9e", out_valid, out_sel, out_data);
      end
      i0 = 8'd0; i1 = 8'd0;
      in0_valid = 1'b1; in0_data = 8'hD0; in0_last = 1'b0;
      in1_data = 8'hE0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         checks++;
         if ({out_valid, out_sel, out_last, out_data} !== {1'b1, exp_sel[k], exp_last[k], exp_d[k]}) begin
            errors++;
            $display("FAIL lock_beat%0d: got v=%b s=%b l=%b d=%h, want v=1 s=%b l=%b d=%h",
                     k, out_valid, out_sel, out_last, out_data, exp_sel[k], exp_last[k], exp_d[k]);
         end
         if (exp_sel[k]) i1 = i1 + 8'd1;
         else i0 = i0 + 8'd1;
         in0_data  = 8'hD0 + i0;
         in0_last  = (i0 == 8'd2);
         in0_valid = (i0 < 8'd3);
         in1_data  = 8'hE0 + i1;
      end
      in0_valid = 1'b0; in1_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL lock_drain: got out_valid=%b, want 0", out_valid);
      end
   endtask

   initial begin
      test_reset();
      test_single_source();
      test_contention();
      test_backpressure();
      test_lock();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
